// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   NOP_INSTR    : instruction returned whenever the CPU must not see program data
//   imem_state_t : loader control states
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    HOLD,
    RUN,
    ERROR
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: DEPTH x 32-bit array with one synchronous write port and
// one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module imem_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-side responder for a single-cycle CPU. Program words arrive on a
// valid/ready load stream and fill the instruction store; the CPU is held in
// reset until a complete program is loaded plus RESET_HOLD cycles. Instr is
// served combinationally from the CPU's PC.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   load_start  : pulse, begin a new load from word 0
//   load_valid  : load_data valid
//   load_data   : instruction word
//   load_last   : final word of the program
//   load_ready  : loader accepts a word this cycle
//   PC          : CPU program counter (byte address)
//   Instr       : instruction to the CPU (combinational)
//   cpu_reset   : active-high reset to the CPU
//   load_done   : program loaded, CPU running
//   load_error  : last load overflowed DEPTH
//   fetch_fault : PC misaligned or beyond the program (combinational)
//   word_count  : words in the current program
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int RESET_HOLD = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [31:0]     load_data,
  input  logic            load_last,
  output logic            load_ready,
  input  logic [31:0]     PC,
  output logic [31:0]     Instr,
  output logic            cpu_reset,
  output logic            load_done,
  output logic            load_error,
  output logic            fetch_fault,
  output logic [ADDR_W:0] word_count
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_END   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  imem_state_t       state;
  imem_state_t       state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hs;
  logic              we;
  logic [31:0]       rdata;
  logic              misaligned;
  logic              beyond;

  assign hs = load_valid & load_ready;
  // A restart wins over a same-cycle handshake, so that word is dropped.
  assign we = hs & ~load_start;

  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = LOADING;
    end else begin
      case (state)
        LOADING: begin
          if (hs) begin
            if (load_last)             state_next = HOLD;
            else if (wr_ptr == LAST_PTR) state_next = ERROR;
          end
        end
        HOLD:    if (hold_cnt == HOLD_END) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  // Control state, pointers and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      if (load_start) begin
        wr_ptr     <= '0;
        word_count <= '0;
      end else begin
        case (state)
          LOADING: begin
            if (hs) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (load_last) begin
                word_count <= {1'b0, wr_ptr} + 1'b1;
                hold_cnt   <= '0;
              end else if (wr_ptr == LAST_PTR) begin
                word_count <= FULL_COUNT;
              end
            end
          end
          HOLD:    hold_cnt <= hold_cnt + 1'b1;
          default: ;
        endcase
      end
      state      <= state_next;
      cpu_reset  <= (state_next != RUN);
      load_ready <= (state_next == LOADING);
      load_done  <= (state_next == RUN);
      load_error <= (state_next == ERROR);
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (PC[ADDR_W+1:2]),
    .rdata (rdata)
  );

  // The full word address is compared, so a PC above the store never wraps.
  assign misaligned = |PC[1:0];
  assign beyond     = PC[31:2] >= 30'(word_count);

  always_comb begin
    Instr       = NOP_INSTR;
    fetch_fault = 1'b0;
    if (!cpu_reset) begin
      if (misaligned || beyond) fetch_fault = 1'b1;
      else                      Instr       = rdata;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized traffic, checked
// each cycle against an event-level model of the loader.
module tb_imem_loader;

  localparam int          DEPTH      = 64;
  localparam int          ADDR_W     = 6;
  localparam int          RESET_HOLD = 2;
  localparam logic [31:0] NOP        = 32'h00000013;

  logic            clk;
  logic            rst_n;
  logic            load_start;
  logic            load_valid;
  logic [31:0]     load_data;
  logic            load_last;
  logic            load_ready;
  logic [31:0]     PC;
  logic [31:0]     Instr;
  logic            cpu_reset;
  logic            load_done;
  logic            load_error;
  logic            fetch_fault;
  logic [ADDR_W:0] word_count;

  imem_loader #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .PC          (PC),
    .Instr       (Instr),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .fetch_fault (fetch_fault),
    .word_count  (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Event-level model: what has been loaded, and on which cycle the CPU is released.
  logic [31:0] m_mem [DEPTH];
  bit          m_loading;
  bit          m_err;
  int          m_wc;
  int          m_ptr;
  int          m_rel_at;
  int          cyc;

  initial begin
    m_loading = 0; m_err = 0; m_wc = 0; m_ptr = 0; m_rel_at = -1; cyc = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_err = 0; m_wc = 0; m_ptr = 0; m_rel_at = -1;
    end else if (load_start) begin
      m_loading = 1; m_err = 0; m_wc = 0; m_ptr = 0; m_rel_at = -1;
    end else if (m_loading && load_valid) begin
      m_mem[m_ptr] = load_data;
      m_ptr++;
      if (load_last) begin
        m_wc      = m_ptr;
        m_loading = 0;
        m_rel_at  = cyc + 1 + RESET_HOLD;
      end else if (m_ptr == DEPTH) begin
        m_wc      = DEPTH;
        m_loading = 0;
        m_err     = 1;
      end
    end
    cyc++;
  end

  bit checking;

  always @(negedge clk) begin : cmp
    bit          run;
    logic [31:0] ei;
    logic        ef;
    if (checking) begin
      run = (m_rel_at >= 0) && (cyc >= m_rel_at);
      ei  = NOP;
      ef  = 1'b0;
      if (run) begin
        if (PC[1:0] != 2'b00 || int'(PC[31:2]) >= m_wc || PC[31:ADDR_W+2] != '0) ef = 1'b1;
        else ei = m_mem[PC[ADDR_W+1:2]];
      end
      check("cpu_reset",   32'(cpu_reset),   32'(!run));
      check("load_done",   32'(load_done),   32'(run));
      check("load_ready",  32'(load_ready),  32'(m_loading));
      check("load_error",  32'(load_error),  32'(m_err));
      check("word_count",  32'(word_count),  32'(m_wc));
      check("Instr",       Instr,            ei);
      check("fetch_fault", 32'(fetch_fault), 32'(ef));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Counts cycles from the one after the last handshake until cpu_reset falls.
  task automatic wait_release(output int n);
    n = 1;
    while (cpu_reset && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic probe(input string name, input logic [31:0] pc,
                       input logic [31:0] exp_instr, input logic exp_fault);
    PC = pc;
    #1;
    check({name, "_instr"}, Instr, exp_instr);
    check({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
  endtask

  logic [31:0] prog [4];
  logic [31:0] gap_words [4];
  int          n;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; PC = '0; checking = 1'b1;
    prog[0] = 32'h00C00193; prog[1] = 32'h00700393;
    prog[2] = 32'h0471AA23; prog[3] = 32'h06002103;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: CPU held, NOP for any PC.
    repeat (5) begin
      PC = $urandom;
      tick();
    end
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("idle_load_ready", 32'(load_ready), 32'd0);
    probe("idle_pc0", 32'd0, NOP, 1'b0);
    probe("idle_pc8", 32'd8, NOP, 1'b0);

    // Four-word program.
    start_load();
    for (int i = 0; i < 4; i++) send(prog[i], i == 3);
    wait_release(n);
    check("release_latency", 32'(n), 32'd3);
    check("prog_word_count", 32'(word_count), 32'd4);
    check("prog_load_done", 32'(load_done), 32'd1);
    for (int i = 0; i < 4; i++) probe("prog_word", 32'(i * 4), prog[i], 1'b0);
    probe("pc16", 32'd16, NOP, 1'b1);
    probe("pc6", 32'd6, NOP, 1'b1);
    probe("pc_huge", 32'h0000_0100, NOP, 1'b1);
    PC = '0;

    // Reload from RUN.
    start_load();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_load_done", 32'(load_done), 32'd0);
    send(32'h00000093, 1'b1);
    wait_release(n);
    check("reload_latency", 32'(n), 32'd3);
    probe("reload_pc0", 32'd0, 32'h00000093, 1'b0);
    probe("reload_pc4", 32'd4, NOP, 1'b1);

    // Overflow: DEPTH words without load_last.
    start_load();
    for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0);
    check("ovf_load_error", 32'(load_error), 32'd1);
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovf_word_count", 32'(word_count), 32'(DEPTH));
    check("ovf_load_ready", 32'(load_ready), 32'd0);
    repeat (3) tick();
    check("ovf_sticky", 32'(load_error), 32'd1);
    start_load();
    check("ovf_cleared", 32'(load_error), 32'd0);
    check("ovf_restart_ready", 32'(load_ready), 32'd1);

    // Gapped stream: idle cycles carry junk data and a stray load_last.
    for (int i = 0; i < 4; i++) begin
      gap_words[i] = $urandom;
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0; load_last = 1'b1; load_data = $urandom;
        tick();
      end
      load_last = 1'b0;
      send(gap_words[i], i == 3);
    end
    wait_release(n);
    check("gap_latency", 32'(n), 32'd3);
    check("gap_word_count", 32'(word_count), 32'd4);
    for (int i = 0; i < 4; i++) probe("gap_word", 32'(i * 4), gap_words[i], 1'b0);
    probe("gap_pc16", 32'd16, NOP, 1'b1);

    // Reset in the middle of a load.
    start_load();
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      load_start = ($urandom_range(0, 59) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) PC = $urandom;
      else PC = (32'($urandom_range(0, DEPTH + 8)) << 2) |
                (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      tick();
    end

    rst_n = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    repeat (3) tick();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
